// File: rtl/obs_pkg.sv
// Shared defaults, control-state encoding and pointer width for the trace compactor.
package obs_pkg;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_QUIET  = 15;

    localparam int PTR_W = $clog2(DEF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_QUIET = 2'd2
    } obs_state_t;

endpackage

// File: rtl/obs_fifo.sv
// Synchronous change FIFO with a registered head so the output never shows X,
// and a push that is still accepted when full as long as a pop frees a slot.
module obs_fifo
    import obs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rptr_q, wptr_q, rptr_d;
    logic [PW:0]       count_q, count_d, remain;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doPop, doPush;

    assign full   = (count_q == (PW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = dout_q;

    // Next read pointer, occupancy and the value that will sit at the head after this edge
    always_comb begin
        rptr_d  = doPop ? rptr_q + 1'b1 : rptr_q;
        remain  = doPop ? count_q - 1'b1 : count_q;
        count_d = doPush ? remain + 1'b1 : remain;
        dout_d  = dout_q;
        if (doPush && remain == '0) begin
            dout_d = din;
        end else if (remain != '0) begin
            dout_d = mem_q[rptr_d];
        end
    end

    // Pointer, occupancy and head registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            if (doPush) begin
                wptr_q <= wptr_q + 1'b1;
            end
        end
    end

    // Storage array; contents are only ever read once written, so no reset is needed
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/obs_trace_compactor.sv
// Observes an upstream block's public output, drops stutter cycles and queues
// only the steps where the public value actually changed.
module obs_trace_compactor
    import obs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int QUIET  = DEF_QUIET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stutter,
    input  logic [DATA_W-1:0] public_in,
    output logic              obs_valid,
    output logic [DATA_W-1:0] obs_data,
    input  logic              obs_ready,
    output logic [CNT_W-1:0]  step_count,
    output logic              quiescent,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] QUIET_C = CNT_W'(QUIET);

    obs_state_t        state_q;
    logic [DATA_W-1:0] last_val_q, last_val_d;
    logic [CNT_W-1:0]  step_count_q, step_count_d;
    logic [CNT_W-1:0]  quiet_q, quiet_d;
    logic              quiescent_q;
    logic              overflow_q, overflow_d;
    logic              isStep, isChange, doPop, fifoFull, fifoEmpty;

    assign isStep   = !stutter;
    assign isChange = isStep && (public_in != last_val_q);
    assign doPop    = obs_valid && obs_ready;

    obs_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (isChange),
        .pop   (doPop),
        .din   (public_in),
        .dout  (obs_data),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign obs_valid  = !fifoEmpty;
    assign step_count = step_count_q;
    assign quiescent  = quiescent_q;
    assign overflow   = overflow_q;

    // Next values for the last-seen value, saturating counters and sticky overflow
    always_comb begin
        last_val_d   = last_val_q;
        step_count_d = step_count_q;
        quiet_d      = quiet_q;
        overflow_d   = overflow_q;
        if (isStep) begin
            if (step_count_q != '1) begin
                step_count_d = step_count_q + 1'b1;
            end
            if (isChange) begin
                last_val_d = public_in;
                quiet_d    = '0;
            end else if (quiet_q != QUIET_C) begin
                quiet_d = quiet_q + 1'b1;
            end
        end
        if (isChange && fifoFull && !doPop) begin
            overflow_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_val_q   <= '0;
            step_count_q <= '0;
            quiet_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            last_val_q   <= last_val_d;
            step_count_q <= step_count_d;
            quiet_q      <= quiet_d;
            overflow_q   <= overflow_d;
        end
    end

    // Control state machine with the registered quiescent flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            quiescent_q <= 1'b0;
        end else begin
            quiescent_q <= (quiet_d == QUIET_C);
            case (state_q)
                ST_IDLE: begin
                    if (isStep) begin
                        state_q <= (quiet_d == QUIET_C) ? ST_QUIET : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (quiet_d == QUIET_C) begin
                        state_q <= ST_QUIET;
                    end
                end
                ST_QUIET: begin
                    if (isChange) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obs_trace_compactor.sv
// Randomised and directed bench for the trace compactor against a queue-based model.
module tb_obs_trace_compactor;

    logic       clk;
    logic       rst;
    logic       stutter;
    logic [1:0] public_in;
    logic       obs_valid;
    logic [1:0] obs_data;
    logic       obs_ready;
    logic [7:0] step_count;
    logic       quiescent;
    logic       overflow;

    int checks = 0;
    int passed = 0;

    // Behavioural model state
    int mq[$];
    int mLast, mSteps, mQuiet, mHold;
    bit mOver;

    obs_trace_compactor dut (
        .clk        (clk),
        .rst        (rst),
        .stutter    (stutter),
        .public_in  (public_in),
        .obs_valid  (obs_valid),
        .obs_data   (obs_data),
        .obs_ready  (obs_ready),
        .step_count (step_count),
        .quiescent  (quiescent),
        .overflow   (overflow)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, advance the model across the edge, return at the falling edge
    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] p, input logic rd);
        bit doPop, isChg, wasFull;
        rst = r; stutter = s; public_in = p; obs_ready = rd;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mLast = 0; mSteps = 0; mQuiet = 0; mHold = 0; mOver = 0;
        end else begin
            doPop   = (mq.size() > 0) && rd;
            isChg   = !s && (int'(p) != mLast);
            wasFull = (mq.size() == 4);
            if (doPop) void'(mq.pop_front());
            if (isChg) begin
                if (!wasFull || doPop) mq.push_back(int'(p));
                else mOver = 1;
                mLast = int'(p);
            end
            if (!s) begin
                if (mSteps < 255) mSteps++;
                if (isChg) mQuiet = 0;
                else if (mQuiet < 15) mQuiet++;
            end
            if (mq.size() > 0) mHold = mq[0];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0);
        checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%0b exp=0", obs_valid); else passed++;
        checks++; if (obs_data !== 2'd0) $display("[TB] FAIL reset_data got=%0d exp=0", obs_data); else passed++;
        checks++; if (step_count !== 8'd0) $display("[TB] FAIL reset_steps got=%0d exp=0", step_count); else passed++;
        checks++; if (quiescent !== 1'b0) $display("[TB] FAIL reset_quiet got=%0b exp=0", quiescent); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf got=%0b exp=0", overflow); else passed++;
    endtask

    task automatic test_idle_steps();
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
            checks++;
            if (quiescent !== (i >= 15)) $display("[TB] FAIL idle_quiet step=%0d got=%0b exp=%0b", i, quiescent, i >= 15);
            else passed++;
        end
        checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL idle_valid got=%0b exp=0", obs_valid); else passed++;
        checks++; if (step_count !== 8'd20) $display("[TB] FAIL idle_steps got=%0d exp=20", step_count); else passed++;
    endtask

    task automatic test_changes();
        logic [1:0] seq [5];
        logic       expV [5];
        logic [1:0] expD [5];
        seq  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        expV = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        expD = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, seq[i], 1'b1);
            checks++;
            if (obs_valid !== expV[i]) $display("[TB] FAIL chg_valid idx=%0d got=%0b exp=%0b", i, obs_valid, expV[i]);
            else passed++;
            checks++;
            if (obs_data !== expD[i]) $display("[TB] FAIL chg_data idx=%0d got=%0d exp=%0d", i, obs_data, expD[i]);
            else passed++;
            if (i == 1) begin
                checks++;
                if (quiescent !== 1'b0) $display("[TB] FAIL chg_quiet got=%0b exp=0", quiescent); else passed++;
            end
        end
    endtask

    task automatic test_stutter();
        logic [7:0] sc;
        logic       qv, vv;
        logic [1:0] vals [3];
        vals = '{2'd3, 2'd1, 2'd3};
        sc = step_count; qv = quiescent; vv = obs_valid;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, vals[i], 1'b0);
        checks++; if (step_count !== sc) $display("[TB] FAIL stut_steps got=%0d exp=%0d", step_count, sc); else passed++;
        checks++; if (obs_valid !== vv) $display("[TB] FAIL stut_valid got=%0b exp=%0b", obs_valid, vv); else passed++;
        checks++; if (quiescent !== qv) $display("[TB] FAIL stut_quiet got=%0b exp=%0b", quiescent, qv); else passed++;
        // last value is still 0, so a step at 0 is not a change
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL stut_nochg got=%0b exp=0", obs_valid); else passed++;
    endtask

    task automatic test_overflow();
        logic [1:0] chg [5];
        logic [1:0] exp4 [4];
        int n;
        chg  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        exp4 = '{2'd1, 2'd2, 2'd3, 2'd1};
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, chg[i], 1'b0);
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag got=%0b exp=1", overflow); else passed++;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (obs_valid === 1'b1) begin
                if (n < 4) begin
                    checks++;
                    if (obs_data !== exp4[n]) $display("[TB] FAIL ovf_drain idx=%0d got=%0d exp=%0d", n, obs_data, exp4[n]);
                    else passed++;
                end
                n++;
            end
            applyStimulus(1'b0, 1'b1, 2'd0, 1'b1);
        end
        checks++; if (n !== 4) $display("[TB] FAIL ovf_count got=%0d exp=4", n); else passed++;
        checks++; if (obs_data !== 2'd1) $display("[TB] FAIL ovf_hold got=%0d exp=1", obs_data); else passed++;
    endtask

    task automatic test_full_pop();
        logic [1:0] fill [4];
        logic [1:0] exp4 [4];
        int n;
        fill = '{2'd1, 2'd2, 2'd3, 2'd1};
        exp4 = '{2'd2, 2'd3, 2'd1, 2'd3};
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, fill[i], 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b1);
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL fp_ovf got=%0b exp=0", overflow); else passed++;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (obs_valid === 1'b1) begin
                if (n < 4) begin
                    checks++;
                    if (obs_data !== exp4[n]) $display("[TB] FAIL fp_drain idx=%0d got=%0d exp=%0d", n, obs_data, exp4[n]);
                    else passed++;
                end
                n++;
            end
            applyStimulus(1'b0, 1'b1, 2'd0, 1'b1);
        end
        checks++; if (n !== 4) $display("[TB] FAIL fp_count got=%0d exp=4", n); else passed++;
    endtask

    task automatic test_saturate();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checks++; if (step_count !== 8'd255) $display("[TB] FAIL sat_steps got=%0d exp=255", step_count); else passed++;
        checks++; if (quiescent !== 1'b1) $display("[TB] FAIL sat_quiet got=%0b exp=1", quiescent); else passed++;
    endtask

    task automatic test_random();
        logic       r, s, rd;
        logic [1:0] p;
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) != 0);
            p  = ($urandom_range(0, 99) < 12) ? 2'($urandom_range(0, 3)) : 2'(mLast);
            applyStimulus(r, s, p, rd);
            checks++;
            if (obs_valid !== (mq.size() > 0)) $display("[TB] FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, obs_valid, mq.size() > 0);
            else passed++;
            checks++;
            if (int'(obs_data) != mHold) $display("[TB] FAIL rnd_data cyc=%0d got=%0d exp=%0d", i, obs_data, mHold);
            else passed++;
            checks++;
            if (int'(step_count) != mSteps) $display("[TB] FAIL rnd_steps cyc=%0d got=%0d exp=%0d", i, step_count, mSteps);
            else passed++;
            checks++;
            if (quiescent !== (mQuiet == 15)) $display("[TB] FAIL rnd_quiet cyc=%0d got=%0b exp=%0b", i, quiescent, mQuiet == 15);
            else passed++;
            checks++;
            if (overflow !== mOver) $display("[TB] FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", i, overflow, mOver);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b0);
        checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL mr_pre got=%0b exp=1", obs_valid); else passed++;
        applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
        checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL mr_valid got=%0b exp=0", obs_valid); else passed++;
        checks++; if (obs_data !== 2'd0) $display("[TB] FAIL mr_data got=%0d exp=0", obs_data); else passed++;
        checks++; if (step_count !== 8'd0) $display("[TB] FAIL mr_steps got=%0d exp=0", step_count); else passed++;
        checks++; if (quiescent !== 1'b0) $display("[TB] FAIL mr_quiet got=%0b exp=0", quiescent); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL mr_ovf got=%0b exp=0", overflow); else passed++;
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1; stutter = 1'b0; public_in = 2'd0; obs_ready = 1'b0;
        mLast = 0; mSteps = 0; mQuiet = 0; mHold = 0; mOver = 0;
        @(negedge clk);
        test_reset();
        test_idle_steps();
        test_changes();
        test_stutter();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/obs_trace_compactor.md
Name: obs_trace_compactor

Overview:
- Downstream observer for the stutter-annotated code blocks in the compiler-optimisation case studies.
- Consumes the registered public output and stutter flag of a code block.
- Discards stutter cycles and compacts the public trace into a FIFO of distinct observation changes.
- Exposes step count and quiescence status, so source and target blocks can be compared change-by-change rather than cycle-by-cycle.

Parameters:
- DATA_W, 2: width of the observed public value.
- DEPTH, 4: change-FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the step counter.
- QUIET, 15: consecutive unchanged steps before quiescent asserts; 1 <= QUIET < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stutter  in  1  registered stutter flag from the upstream code block; 1 = this cycle is not a program step.
- public_in  in  DATA_W  registered public output from the upstream code block.
- obs_valid  out  1  FIFO head valid.
- obs_data  out  DATA_W  FIFO head value.
- obs_ready  in  1  consumer accepts the head.
- step_count  out  CNT_W  non-stutter cycles since reset; saturating.
- quiescent  out  1  no change seen for QUIET consecutive steps.
- overflow  out  1  sticky; a change was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, obs_valid=0, obs_data=0, step_count=0, quiescent=0, overflow=0, last_val=0.
  - last_val=0 matches the upstream public_out reset value.
  - Reset takes priority over every other event, including a mid-operation pop.
- Step: a cycle with stutter=0.
  - Stutter cycles change nothing: counters hold, no push, no quiet advance.
  - Pops still occur during stutter cycles.
- Change: a step with public_in != last_val.
  - On a change, last_val <= public_in at the same edge.
  - public_in is ignored on stutter cycles, even if it differs.
- step_count: +1 per step; saturates at 2^CNT_W-1 with no wrap.
- Quiet counter:
  - Cleared to 0 on a change.
  - +1 on a non-change step, saturating at QUIET.
  - quiescent = (quiet counter == QUIET), registered.
  - quiescent drops in the cycle after the edge that saw a change.
- FIFO push: on a change.
  - Accepted if the FIFO is not full, or if a pop happens at the same edge; a simultaneous pop+push when full keeps count=DEPTH.
  - Rejected when full with no pop: value dropped, overflow <= 1.
  - overflow is cleared only by rst.
  - last_val still updates on a dropped change, so the next differing value is a new change.
- FIFO pop: at an edge where obs_valid && obs_ready. obs_ready while empty is ignored.
- Latency: a value pushed at edge N appears on obs_valid/obs_data after edge N when the FIFO was empty. No combinational path from public_in to the outputs.
- obs_data: holds the head while valid; holds the last head (not X) when empty.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Occupancy counter has log2(DEPTH)+1 bits; full = (count == DEPTH), empty = (count == 0).
- Control state: IDLE (no step yet), RUN (steps seen), QUIET (quiescent=1).
  - IDLE->RUN on the first step.
  - RUN->QUIET when the quiet counter reaches QUIET.
  - QUIET->RUN on a change.
  - Any state->IDLE on rst.
- Arithmetic: all comparisons are unsigned, DATA_W-bit equality.

Decomposition:
- Package obs_pkg:
  - DATA_W, DEPTH, CNT_W, QUIET defaults.
  - obs_state_t enum {IDLE, RUN, QUIET}.
  - Localparam PTR_W = $clog2(DEPTH).
- Sub-module obs_fifo: synchronous DEPTH x DATA_W FIFO.
  - Ports: push, pop, din, dout, full, empty; same clk/rst.
  - Implements the full+pop push acceptance rule.
- Top level: change detection, counters, state machine, overflow flag.

Test Plan:
- Reset, then stutter=0 with public_in=0 for 20 cycles -> no obs_valid, step_count=20, quiescent=1 after the 15th step.
- public_in 0,1,1,2,0 on steps, obs_ready=1 -> obs_data stream 1,2,0, each one cycle after its change edge; quiescent=0 after the change.
- Stutter=1 for 3 cycles with public_in toggling 3,1,3 -> no push, step_count unchanged, quiet counter frozen.
- obs_ready=0, five changes 1,2,3,1,2 -> FIFO holds 1,2,3,1; overflow=1; draining yields exactly those four values.
- FIFO full, a change (value 3) coincides with a pop -> push accepted, count stays 4, overflow stays 0.
- 300 steps with CNT_W=8 -> step_count=255. Assert rst mid-stream with FIFO non-empty -> all outputs zero next cycle.
